bsg_front_side_bus_hop_out_no_fc: RTL and testbench

BSG_FRONT_SIDE_BUS_HOP_OUT_NO_FC -- requirements
Module: bsg_front_side_bus_hop_out_no_fc

---
 rtl/bsg_front_side_bus_hop_out_no_fc.sv | 129 ++++++++++++
 tb/tb_bsg_front_side_bus_hop_out_no_fc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_front_side_bus_hop_out_no_fc.sv
// Front-side bus hop-out stage without flow control.
// Merges a pass-through flit stream with a local injection FIFO into one
// registered output. Pass-through has strict priority and is always accepted.
// Optional macro BSG_FSB_HOP_OUT_STALL_COUNT_EN enables a saturating counter of
// cycles where local traffic was blocked by pass-through traffic.
module bsg_front_side_bus_hop_out_no_fc #(
  parameter int unsigned width_p     = 16,
  parameter int unsigned local_els_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  input  logic [width_p-1:0] local_data_i,
  input  logic               local_v_i,
  output logic               local_ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic [15:0]        stall_count_o
);

  localparam int unsigned ptr_w_lp = (local_els_p > 1) ? $clog2(local_els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(local_els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(local_els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(local_els_p);

  logic [width_p-1:0]  mem_q [local_els_p];
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                v_q, v_d;
  logic [width_p-1:0]  data_q, data_d;

  logic fifo_empty;
  logic fifo_full;
  logic enq;
  logic deq;

  // Occupancy counter keeps full and empty distinct at any depth.
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == full_cnt_lp);

  // Ready comes only from registered occupancy; held low while in reset.
  assign local_ready_o = ~fifo_full & ~reset_i;

  // A full FIFO never enqueues, even when the head leaves this cycle.
  assign enq = local_v_i & local_ready_o;
  // The head only leaves when the pass-through slot is idle.
  assign deq = ~v_i & ~fifo_empty;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    next_ptr = (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Next-state for FIFO pointers, occupancy and the output register.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    v_d    = v_i | ~fifo_empty;
    data_d = data_q;

    if (enq) wptr_d = next_ptr(wptr_q);
    if (deq) rptr_d = next_ptr(rptr_q);

    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
      default: cnt_d = cnt_q;
    endcase

    if (v_i) begin
      data_d = data_i;
    end else if (~fifo_empty) begin
      data_d = mem_q[rptr_q];
    end
  end

  // Control state with synchronous reset; buffered flits are discarded.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      v_q    <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      v_q    <= v_d;
    end
  end

  // Output data register is not reset; it holds when nothing is sent.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  // FIFO storage write; never bypasses to the output in the same cycle.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= local_data_i;
  end

  assign v_o    = v_q;
  assign data_o = data_q;

`ifdef BSG_FSB_HOP_OUT_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles where a waiting local flit lost to pass-through; saturates.
  always_comb begin
    stall_d = stall_q;
    if (v_i && !fifo_empty && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register; cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_count_o = stall_q;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_no_fc.sv
// Directed table-driven bench for bsg_front_side_bus_hop_out_no_fc.
module tb_bsg_front_side_bus_hop_out_no_fc;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] data_i;
  logic        v_i;
  logic [15:0] local_data_i;
  logic        local_v_i;
  logic        local_ready_o;
  logic [15:0] data_o;
  logic        v_o;
  logic [15:0] stall_count_o;

`ifdef BSG_FSB_HOP_OUT_STALL_COUNT_EN
  localparam bit stall_en = 1'b1;
`else
  localparam bit stall_en = 1'b0;
`endif

  bsg_front_side_bus_hop_out_no_fc #(.width_p(16), .local_els_p(2)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .data_i        (data_i),
    .v_i           (v_i),
    .local_data_i  (local_data_i),
    .local_v_i     (local_v_i),
    .local_ready_o (local_ready_o),
    .data_o        (data_o),
    .v_o           (v_o),
    .stall_count_o (stall_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        lv;
    logic [15:0] ld;
    logic        ev;
    logic [15:0] ed;
    logic        er;
    logic [15:0] es;
  } vec_t;

  vec_t tbl [19];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  function automatic vec_t mk(input logic v, input logic [15:0] d,
                              input logic lv, input logic [15:0] ld,
                              input logic ev, input logic [15:0] ed,
                              input logic er, input logic [15:0] es);
    vec_t r;
    r.v = v; r.d = d; r.lv = lv; r.ld = ld;
    r.ev = ev; r.ed = ed; r.er = er; r.es = es;
    return r;
  endfunction

  function automatic logic [15:0] exp_stall(input logic [15:0] s);
    return stall_en ? s : 16'h0000;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic lv, input logic [15:0] ld);
    v_i = v; data_i = d; local_v_i = lv; local_data_i = ld;
  endtask

  // Apply current inputs across one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0);

    // Reset state
    tick();
    tick();
    chk("rst_v_o", 16'(v_o), 16'h0);
    chk("rst_ready", 16'(local_ready_o), 16'h0);
    chk("rst_stall", stall_count_o, 16'h0);
    reset_i = 1'b0;
    #1;
    chk("ready_after_rst", 16'(local_ready_o), 16'h1);

    //            v     d        lv    ld       ev    ed       er    stall
    tbl[0]  = mk(1'b1, 16'hA5A5, 1'b0, 16'h0000, 1'b1, 16'hA5A5, 1'b1, 16'd0);
    tbl[1]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'd0);
    tbl[2]  = mk(1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'd0);
    tbl[3]  = mk(1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0001, 1'b1, 16'd0);
    tbl[4]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'd0);
    tbl[5]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'd0);
    tbl[6]  = mk(1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0, 16'h0000, 1'b1, 16'd0);
    tbl[7]  = mk(1'b1, 16'hB000, 1'b0, 16'h0000, 1'b1, 16'hB000, 1'b1, 16'd1);
    tbl[8]  = mk(1'b1, 16'hB001, 1'b0, 16'h0000, 1'b1, 16'hB001, 1'b1, 16'd2);
    tbl[9]  = mk(1'b1, 16'hB002, 1'b0, 16'h0000, 1'b1, 16'hB002, 1'b1, 16'd3);
    tbl[10] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b1, 16'd3);
    tbl[11] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'd3);
    tbl[12] = mk(1'b1, 16'hD000, 1'b1, 16'hC001, 1'b1, 16'hD000, 1'b1, 16'd3);
    tbl[13] = mk(1'b1, 16'hD001, 1'b1, 16'hC002, 1'b1, 16'hD001, 1'b0, 16'd4);
    tbl[14] = mk(1'b1, 16'hD002, 1'b1, 16'hC003, 1'b1, 16'hD002, 1'b0, 16'd5);
    tbl[15] = mk(1'b0, 16'h0000, 1'b1, 16'hC003, 1'b1, 16'hC001, 1'b1, 16'd5);
    tbl[16] = mk(1'b0, 16'h0000, 1'b1, 16'hC003, 1'b1, 16'hC002, 1'b1, 16'd5);
    tbl[17] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hC003, 1'b1, 16'd5);
    tbl[18] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'd5);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].lv, tbl[i].ld);
      tick();
      chk($sformatf("vec%0d_v_o", i), 16'(v_o), 16'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_data_o", i), data_o, tbl[i].ed);
      chk($sformatf("vec%0d_ready", i), 16'(local_ready_o), 16'(tbl[i].er));
      chk($sformatf("vec%0d_stall", i), stall_count_o, exp_stall(tbl[i].es));
    end

    // Reset mid-flight with two buffered flits and pass-through active
    drive(1'b1, 16'hF000, 1'b1, 16'hE001);
    tick();
    drive(1'b1, 16'hF001, 1'b1, 16'hE002);
    tick();
    chk("mid_full_ready", 16'(local_ready_o), 16'h0);
    chk("mid_stall_pre", stall_count_o, exp_stall(16'd6));
    reset_i = 1'b1;
    drive(1'b1, 16'hF002, 1'b0, 16'h0);
    tick();
    chk("mid_rst_v_o", 16'(v_o), 16'h0);
    chk("mid_rst_stall", stall_count_o, 16'h0);
    chk("mid_rst_ready", 16'(local_ready_o), 16'h0);
    reset_i = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    chk("mid_ready_after", 16'(local_ready_o), 16'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_drain%0d_v_o", i), 16'(v_o), 16'h0);
    end

    // Simultaneous enqueue/dequeue keeps occupancy at one
    drive(1'b0, 16'h0, 1'b1, 16'h7001);
    tick();
    drive(1'b0, 16'h0, 1'b1, 16'h7002);
    tick();
    chk("sim_ready", 16'(local_ready_o), 16'h1);
    chk("sim_data0", data_o, 16'h7001);
    drive(1'b1, 16'h9000, 1'b1, 16'h7003);
    tick();
    chk("sim_full_ready", 16'(local_ready_o), 16'h0);
    chk("sim_pass_data", data_o, 16'h9000);
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    tick();
    chk("sim_data1", data_o, 16'h7002);
    tick();
    chk("sim_data2", data_o, 16'h7003);
    tick();
    chk("sim_idle_v_o", 16'(v_o), 16'h0);
    chk("sim_hold_data", data_o, 16'h7003);

`ifdef BSG_FSB_HOP_OUT_STALL_COUNT_EN
    // Saturation: counter must stop at FFFF
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 16'h5555);
    tick();
    drive(1'b1, 16'h1234, 1'b0, 16'h0);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("sat_fffe", stall_count_o, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_count_o, 16'hFFFF);
    for (int i = 0; i < 4465; i++) @(posedge clk);
    #1;
    chk("sat_hold", stall_count_o, 16'hFFFF);
    drive(1'b0, 16'h0, 1'b0, 16'h0);
    tick();
    chk("sat_flit", data_o, 16'h5555);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
